rr_packet_arb: RTL and testbench
================================

// Module: rr_packet_arb
// PURPOSE
//  Parametrised round-robin arbiter for the switch output stage, with wormhole packet lock.
//  Grants one of IN_N input ports per cycle with strong fairness.
//  Once a head flit is accepted, the grant locks to that port until its tail flit transfers.
//  Sits between the input-buffer request lines and the output-port crossbar select.
// PARAMETERS
//  IN_N   5                     number of requesting input ports (>=1)
//  ID_W   (IN_N>1?$clog2(IN_N):1)  width of encoded grant index
// PORTS
//  clk_i          in   1      clock, all state on rising edge
//  rst_i          in   1      reset, asynchronous, active-high
//  req_i          in   IN_N   per-port flit-valid request
//  last_i         in   IN_N   per-port tail marker; qualifies req_i of the same bit
//  ready_i        in   1      downstream (output buffer) can accept a flit this cycle
//  grant_o        out  IN_N   one-hot grant (all-zero = none); crossbar select
//  grant_id_o     out  ID_W   binary index of granted port (0 when grant_o==0)
//  grant_vld_o    out  1      |grant_o
//  locked_o       out  1      arbiter is holding a packet (state LOCKED)
// BEHAVIOUR
//  Interface
//   - One clock, clk_i; asynchronous active-high reset, rst_i.
//  State
//   - Registers: state {IDLE, LOCKED}, ptr[ID_W] (highest-priority port), owner[ID_W].
//   - Reset values: state=IDLE, ptr=0, owner=0.
//   - All outputs are combinational from state and inputs, giving zero-cycle grant latency.
//   - While rst_i=1, grant_o=0, grant_id_o=0, grant_vld_o=0 and locked_o=0, regardless of req_i.
//  IDLE
//   - grant_o selects the first set req_i bit scanning ptr, ptr+1, ..., IN_N-1, 0, ..., ptr-1.
//   - No req_i set -> grant_o=0.
//  LOCKED
//   - grant_o = req_i[owner] ? onehot(owner) : 0.
//   - Other requests are ignored. An owner bubble keeps the lock; it is not re-arbitrated.
//  Transfer and transitions
//   - xfer = grant_vld_o & ready_i.
//   - Let g = grant_id_o.
//   - IDLE, xfer, !last_i[g]: state<=LOCKED, owner<=g. ptr unchanged.
//   - IDLE, xfer, last_i[g] (single-flit packet): stay IDLE, ptr<=g+1 mod IN_N.
//   - LOCKED, xfer, last_i[owner]: state<=IDLE, ptr<=owner+1 mod IN_N.
//   - LOCKED, any other case: hold all state.
//   - No xfer (ready_i=0 or no request): state, ptr and owner hold. A grant shown while ready_i=0 is not committed.
//  Fairness and rotation
//   - The last served port moves to lowest priority only when its packet completes.
//   - A continuously requesting port waits at most IN_N-1 packets.
//   - ptr wrap: the increment from IN_N-1 gives 0. Compare in ID_W+1 bits and never emit an index >= IN_N.
//   - IN_N=1: ptr stays 0. The lock still operates. grant_id_o is tied to 0.
//  Edge cases
//   - Tail with req_i[owner]=0: last_i is ignored and the lock holds.
//   - last_i on a non-granted port has no effect.
//   - Reset mid-packet: lock released and ptr=0 immediately (async). The first cycle after reset arbitrates from port 0.
// TESTING
//  1. Reset then req=5'b11111, ready=1, last=all-1 for 5 cycles -> grant_id sequence 0,1,2,3,4; locked_o stays 0.
//  2. Port 2 sends a 4-flit packet (last on flit 4) with ports 0 and 4 requesting throughout
//     -> grant=5'b00100 for 4 xfers, locked_o=1 for cycles 2-4; next grant_id=4, then 0.
//  3. Locked on port 1, ready_i=0 for 3 cycles, then req_i[1] low for 2 cycles with others requesting
//     -> grant_o=5'b00010 during the ready stall; grant_o=0 during the req gap; no switch until port 1 tail.
//  4. ptr=4 (after serving port 3), req=5'b10001, single flits -> grant_id=4 then 0 (wrap), then 4 again.
//  5. Assert rst_i asynchronously mid-packet (locked on port 3)
//     -> grant_o=0 and locked_o=0 within the same cycle; after release with req=5'b01001, grant_id=0.
//  6. IN_N=1 and IN_N=8 builds: random req/last/ready for 10k cycles
//     -> grant one-hot-or-zero, subset of req_i, no port starved beyond IN_N-1 packets.

Source files
------------

// File: rtl/rr_packet_arb_if.sv
// Handshake bundle between the input-buffer request lines and the output-stage arbiter.
// The master modport drives requests; the slave modport is the arbiter side.
interface rr_packet_arb_if #(
  parameter int IN_N = 5,
  parameter int ID_W = (IN_N > 1) ? $clog2(IN_N) : 1
);
  logic [IN_N-1:0] req_i;
  logic [IN_N-1:0] last_i;
  logic            ready_i;
  logic [IN_N-1:0] grant_o;
  logic [ID_W-1:0] grant_id_o;
  logic            grant_vld_o;
  logic            locked_o;

  modport master (
    output req_i, last_i, ready_i,
    input  grant_o, grant_id_o, grant_vld_o, locked_o
  );

  modport slave (
    input  req_i, last_i, ready_i,
    output grant_o, grant_id_o, grant_vld_o, locked_o
  );
endinterface

// File: rtl/rr_packet_arb.sv
// Round-robin output-stage arbiter with wormhole packet lock; zero-cycle combinational grant.
//   state  | meaning
//   IDLE   | arbitrate among all requesters starting at ptr
//   LOCKED | grant held by owner until its tail flit transfers
module rr_packet_arb #(
  parameter int IN_N = 5,
  parameter int ID_W = (IN_N > 1) ? $clog2(IN_N) : 1
) (
  input logic           clk_i,
  input logic           rst_i,
  rr_packet_arb_if.slave bus
);

  typedef enum logic {IDLE, LOCKED} state_t;

  localparam logic [ID_W:0] N_W = (ID_W+1)'(IN_N);

  state_t          state;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] owner;

  logic [IN_N-1:0] arb_grant;
  logic            arb_hit;
  logic [ID_W:0]   scan_idx;
  logic [IN_N-1:0] owner_oh;
  logic [IN_N-1:0] grant;
  logic [ID_W-1:0] grant_id;
  logic            grant_vld;
  logic            xfer;
  logic            tail;

  // Index arithmetic is done one bit wider so the wrap never aliases an illegal port.
  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] v);
    logic [ID_W:0] s;
    s = {1'b0, v} + (ID_W+1)'(1);
    if (s >= N_W) s = '0;
    return s[ID_W-1:0];
  endfunction

  always_comb begin
    arb_grant = '0;
    arb_hit   = 1'b0;
    scan_idx  = '0;
    for (int i = 0; i < IN_N; i++) begin
      scan_idx = {1'b0, ptr} + (ID_W+1)'(i);
      if (scan_idx >= N_W) scan_idx = scan_idx - N_W;
      for (int j = 0; j < IN_N; j++) begin
        if (!arb_hit && bus.req_i[j] && (scan_idx == (ID_W+1)'(j))) begin
          arb_hit      = 1'b1;
          arb_grant[j] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    owner_oh = '0;
    for (int j = 0; j < IN_N; j++) begin
      if (owner == ID_W'(j)) owner_oh[j] = 1'b1;
    end
  end

  // Reset forces the grant off even though the IDLE arbiter would otherwise see requests.
  always_comb begin
    grant = '0;
    if (!rst_i) begin
      if (state == LOCKED) grant = bus.req_i & owner_oh;
      else                 grant = arb_grant;
    end
  end

  always_comb begin
    grant_id = '0;
    for (int j = 0; j < IN_N; j++) begin
      if (grant[j]) grant_id = ID_W'(j);
    end
  end

  assign grant_vld = |grant;
  assign xfer      = grant_vld & bus.ready_i;
  assign tail      = |(grant & bus.last_i);

  assign bus.grant_o     = grant;
  assign bus.grant_id_o  = (IN_N == 1) ? '0 : grant_id;
  assign bus.grant_vld_o = grant_vld;
  assign bus.locked_o    = (state == LOCKED) & ~rst_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      ptr   <= '0;
      owner <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            if (tail) begin
              ptr <= wrap_inc(grant_id);
            end else begin
              state <= LOCKED;
              owner <= grant_id;
            end
          end
        end
        LOCKED: begin
          // A bubble on the owner keeps the lock; only its tail releases it.
          if (xfer && tail) begin
            state <= IDLE;
            ptr   <= wrap_inc(owner);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_packet_arb.sv
// Directed checks of the 5-port arbiter plus randomised model checks of 1- and 8-port builds.
module tb_rr_packet_arb;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   assertions = 0;
  int   failures   = 0;

  always #5 clk_i = ~clk_i;

  rr_packet_arb_if #(.IN_N(5), .ID_W(3)) bus5 ();
  rr_packet_arb_if #(.IN_N(1), .ID_W(1)) bus1 ();
  rr_packet_arb_if #(.IN_N(8), .ID_W(3)) bus8 ();

  rr_packet_arb #(.IN_N(5), .ID_W(3)) dut5 (.clk_i(clk_i), .rst_i(rst_i), .bus(bus5));
  rr_packet_arb #(.IN_N(1), .ID_W(1)) dut1 (.clk_i(clk_i), .rst_i(rst_i), .bus(bus1));
  rr_packet_arb #(.IN_N(8), .ID_W(3)) dut8 (.clk_i(clk_i), .rst_i(rst_i), .bus(bus8));

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive5(input logic [4:0] req, input logic [4:0] last, input logic rdy);
    bus5.req_i   = req;
    bus5.last_i  = last;
    bus5.ready_i = rdy;
  endtask

  task automatic test_reset();
    drive5(5'b11111, 5'b11111, 1'b1);
    #2;
    assertions++; if (bus5.grant_o !== 5'b00000) begin failures++; $display("FAIL rst_grant got %b want 00000", bus5.grant_o); end
    assertions++; if (bus5.grant_id_o !== 3'd0) begin failures++; $display("FAIL rst_id got %0d want 0", bus5.grant_id_o); end
    assertions++; if (bus5.grant_vld_o !== 1'b0) begin failures++; $display("FAIL rst_vld got %b want 0", bus5.grant_vld_o); end
    assertions++; if (bus5.locked_o !== 1'b0) begin failures++; $display("FAIL rst_locked got %b want 0", bus5.locked_o); end
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_rotation();
    logic [2:0] eid;
    logic [4:0] eg;
    for (int i = 0; i < 5; i++) begin
      eid = 3'(i);
      eg  = 5'b00001 << i;
      drive5(5'b11111, 5'b11111, 1'b1);
      #1;
      assertions++; if (bus5.grant_id_o !== eid) begin failures++; $display("FAIL rot_id step%0d got %0d want %0d", i, bus5.grant_id_o, eid); end
      assertions++; if (bus5.grant_o !== eg) begin failures++; $display("FAIL rot_grant step%0d got %b want %b", i, bus5.grant_o, eg); end
      assertions++; if (bus5.locked_o !== 1'b0) begin failures++; $display("FAIL rot_locked step%0d got %b want 0", i, bus5.locked_o); end
      tick();
    end
  endtask

  task automatic test_packet();
    logic el;
    drive5(5'b00001, 5'b11111, 1'b1);
    #1;
    assertions++; if (bus5.grant_id_o !== 3'd0) begin failures++; $display("FAIL pkt_pre_id got %0d want 0", bus5.grant_id_o); end
    tick();
    for (int f = 1; f <= 4; f++) begin
      drive5(5'b10101, (f == 4) ? 5'b10101 : 5'b10001, 1'b1);
      el = (f > 1);
      #1;
      assertions++; if (bus5.grant_o !== 5'b00100) begin failures++; $display("FAIL pkt_grant flit%0d got %b want 00100", f, bus5.grant_o); end
      assertions++; if (bus5.locked_o !== el) begin failures++; $display("FAIL pkt_locked flit%0d got %b want %b", f, bus5.locked_o, el); end
      tick();
    end
    drive5(5'b10001, 5'b10001, 1'b1);
    #1;
    assertions++; if (bus5.grant_id_o !== 3'd4) begin failures++; $display("FAIL pkt_next_id got %0d want 4", bus5.grant_id_o); end
    tick();
    drive5(5'b10001, 5'b10001, 1'b1);
    #1;
    assertions++; if (bus5.grant_id_o !== 3'd0) begin failures++; $display("FAIL pkt_after_id got %0d want 0", bus5.grant_id_o); end
    tick();
  endtask

  task automatic test_stall();
    drive5(5'b00010, 5'b00000, 1'b1);
    #1;
    assertions++; if (bus5.grant_o !== 5'b00010) begin failures++; $display("FAIL stall_head got %b want 00010", bus5.grant_o); end
    assertions++; if (bus5.locked_o !== 1'b0) begin failures++; $display("FAIL stall_head_locked got %b want 0", bus5.locked_o); end
    tick();
    for (int c = 0; c < 3; c++) begin
      drive5(5'b11111, 5'b00010, 1'b0);
      #1;
      assertions++; if (bus5.grant_o !== 5'b00010) begin failures++; $display("FAIL stall_ready_grant c%0d got %b want 00010", c, bus5.grant_o); end
      assertions++; if (bus5.locked_o !== 1'b1) begin failures++; $display("FAIL stall_ready_locked c%0d got %b want 1", c, bus5.locked_o); end
      tick();
    end
    for (int c = 0; c < 2; c++) begin
      drive5(5'b11101, 5'b11111, 1'b1);
      #1;
      assertions++; if (bus5.grant_o !== 5'b00000) begin failures++; $display("FAIL stall_gap_grant c%0d got %b want 00000", c, bus5.grant_o); end
      assertions++; if (bus5.grant_vld_o !== 1'b0) begin failures++; $display("FAIL stall_gap_vld c%0d got %b want 0", c, bus5.grant_vld_o); end
      assertions++; if (bus5.locked_o !== 1'b1) begin failures++; $display("FAIL stall_gap_locked c%0d got %b want 1", c, bus5.locked_o); end
      tick();
    end
    drive5(5'b11111, 5'b00000, 1'b1);
    #1;
    assertions++; if (bus5.grant_o !== 5'b00010) begin failures++; $display("FAIL stall_body got %b want 00010", bus5.grant_o); end
    assertions++; if (bus5.locked_o !== 1'b1) begin failures++; $display("FAIL stall_body_locked got %b want 1", bus5.locked_o); end
    tick();
    drive5(5'b11111, 5'b00010, 1'b1);
    #1;
    assertions++; if (bus5.grant_o !== 5'b00010) begin failures++; $display("FAIL stall_tail got %b want 00010", bus5.grant_o); end
    assertions++; if (bus5.locked_o !== 1'b1) begin failures++; $display("FAIL stall_tail_locked got %b want 1", bus5.locked_o); end
    tick();
    drive5(5'b11111, 5'b11111, 1'b1);
    #1;
    assertions++; if (bus5.grant_id_o !== 3'd2) begin failures++; $display("FAIL stall_next_id got %0d want 2", bus5.grant_id_o); end
    assertions++; if (bus5.locked_o !== 1'b0) begin failures++; $display("FAIL stall_next_locked got %b want 0", bus5.locked_o); end
    tick();
  endtask

  task automatic test_wrap();
    logic [2:0] exp_ids [4];
    exp_ids = '{3'd3, 3'd4, 3'd0, 3'd4};
    for (int k = 0; k < 4; k++) begin
      drive5((k == 0) ? 5'b01000 : 5'b10001, 5'b11111, 1'b1);
      #1;
      assertions++; if (bus5.grant_id_o !== exp_ids[k]) begin failures++; $display("FAIL wrap_id step%0d got %0d want %0d", k, bus5.grant_id_o, exp_ids[k]); end
      tick();
    end
  endtask

  task automatic test_async_reset();
    drive5(5'b01000, 5'b00000, 1'b1);
    #1;
    assertions++; if (bus5.grant_id_o !== 3'd3) begin failures++; $display("FAIL arst_head_id got %0d want 3", bus5.grant_id_o); end
    tick();
    drive5(5'b01001, 5'b00000, 1'b1);
    #1;
    assertions++; if (bus5.grant_o !== 5'b01000) begin failures++; $display("FAIL arst_lock_grant got %b want 01000", bus5.grant_o); end
    assertions++; if (bus5.locked_o !== 1'b1) begin failures++; $display("FAIL arst_lock_locked got %b want 1", bus5.locked_o); end
    #2;
    rst_i = 1'b1;
    #2;
    assertions++; if (bus5.grant_o !== 5'b00000) begin failures++; $display("FAIL arst_grant got %b want 00000", bus5.grant_o); end
    assertions++; if (bus5.locked_o !== 1'b0) begin failures++; $display("FAIL arst_locked got %b want 0", bus5.locked_o); end
    assertions++; if (bus5.grant_vld_o !== 1'b0) begin failures++; $display("FAIL arst_vld got %b want 0", bus5.grant_vld_o); end
    tick();
    rst_i = 1'b0;
    drive5(5'b01001, 5'b00000, 1'b1);
    #1;
    assertions++; if (bus5.grant_id_o !== 3'd0) begin failures++; $display("FAIL arst_after_id got %0d want 0", bus5.grant_id_o); end
    assertions++; if (bus5.grant_o !== 5'b00001) begin failures++; $display("FAIL arst_after_grant got %b want 00001", bus5.grant_o); end
    assertions++; if (bus5.locked_o !== 1'b0) begin failures++; $display("FAIL arst_after_locked got %b want 0", bus5.locked_o); end
    tick();
    drive5(5'b00000, 5'b00000, 1'b0);
  endtask

  task automatic test_random(input int n, input int cycles);
    logic [7:0] r, l, dg, eg, mask;
    logic       rdy, dv, dl;
    int         did, eid, m_ptr, m_owner, p;
    bit         m_locked, hit;
    int         wc [8];
    mask = 8'((1 << n) - 1);
    r = '0; l = '0;
    m_locked = 1'b0; m_ptr = 0; m_owner = 0;
    for (int q = 0; q < 8; q++) wc[q] = 0;
    for (int c = 0; c < cycles; c++) begin
      for (int q = 0; q < 8; q++) begin
        if ($urandom_range(0, 7) == 0) r[q] = ~r[q];
        l[q] = ($urandom_range(0, 3) == 0);
      end
      r = r & mask;
      l = l & mask;
      rdy = ($urandom_range(0, 3) != 0);
      if (n == 1) begin
        bus1.req_i = r[0:0]; bus1.last_i = l[0:0]; bus1.ready_i = rdy;
      end else begin
        bus8.req_i = r; bus8.last_i = l; bus8.ready_i = rdy;
      end
      #1;
      if (n == 1) begin
        dg = {7'b0, bus1.grant_o}; did = int'(bus1.grant_id_o); dv = bus1.grant_vld_o; dl = bus1.locked_o;
      end else begin
        dg = bus8.grant_o; did = int'(bus8.grant_id_o); dv = bus8.grant_vld_o; dl = bus8.locked_o;
      end
      eg = '0; eid = 0;
      if (m_locked) begin
        if (r[m_owner]) begin eg[m_owner] = 1'b1; eid = m_owner; end
      end else begin
        hit = 1'b0;
        for (int i = 0; i < n; i++) begin
          p = (m_ptr + i) % n;
          if (!hit && r[p]) begin hit = 1'b1; eg[p] = 1'b1; eid = p; end
        end
      end
      assertions++; if (dg !== eg) begin failures++; $display("FAIL rnd%0d_grant cyc%0d got %b want %b", n, c, dg, eg); end
      assertions++; if (did != eid) begin failures++; $display("FAIL rnd%0d_id cyc%0d got %0d want %0d", n, c, did, eid); end
      assertions++; if (dv !== (|eg)) begin failures++; $display("FAIL rnd%0d_vld cyc%0d got %b want %b", n, c, dv, |eg); end
      assertions++; if (dl !== m_locked) begin failures++; $display("FAIL rnd%0d_locked cyc%0d got %b want %b", n, c, dl, m_locked); end
      assertions++; if (!$onehot0(dg) || ((dg & ~r) != 8'd0)) begin failures++; $display("FAIL rnd%0d_onehot_subset cyc%0d got %b want subset of %b", n, c, dg, r); end
      if ((|eg) && rdy) begin
        wc[eid] = 0;
        if (l[eid]) begin
          for (int q = 0; q < n; q++) if (q != eid && r[q]) wc[q]++;
          for (int q = 0; q < n; q++) begin
            assertions++; if (wc[q] > n - 1) begin failures++; $display("FAIL rnd%0d_starve port%0d cyc%0d got %0d want <= %0d", n, q, c, wc[q], n - 1); end
          end
          m_locked = 1'b0;
          m_ptr = (eid + 1) % n;
        end else if (!m_locked) begin
          m_locked = 1'b1;
          m_owner = eid;
        end
      end
      for (int q = 0; q < 8; q++) if (!r[q]) wc[q] = 0;
      tick();
    end
    if (n == 1) begin
      bus1.req_i = '0; bus1.last_i = '0; bus1.ready_i = 1'b0;
    end else begin
      bus8.req_i = '0; bus8.last_i = '0; bus8.ready_i = 1'b0;
    end
  endtask

  initial begin
    bus5.req_i = '0; bus5.last_i = '0; bus5.ready_i = 1'b0;
    bus1.req_i = '0; bus1.last_i = '0; bus1.ready_i = 1'b0;
    bus8.req_i = '0; bus8.last_i = '0; bus8.ready_i = 1'b0;
    test_reset();
    test_rotation();
    test_packet();
    test_stall();
    test_wrap();
    test_async_reset();
    test_random(1, 10000);
    test_random(8, 10000);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
